// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//
// Purpose: one cache-line memory port. The same bundle is used for the
// instruction-cache side, the data-cache side and the downstream memory side
// of mem_arbiter, so each cache sees exactly the handshake it would see on a
// private port.
//
// Signals:
//   request  : requester -> responder, level request
//   wrenable : requester -> responder, 1 = write, 0 = read
//   addr     : requester -> responder, byte address of the line
//   wdata    : requester -> responder, writeback line
//   reqack   : responder -> requester, request accepted
//   rdata    : responder -> requester, read line
//   done     : responder -> requester, transaction complete
//
// Modports:
//   master : the side that issues requests
//   slave  : the side that accepts and completes them
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AddrWidth = 64,
  parameter int LineWidth = 512
);

  logic                 request;
  logic                 wrenable;
  logic [AddrWidth-1:0] addr;
  logic [LineWidth-1:0] wdata;
  logic                 reqack;
  logic [LineWidth-1:0] rdata;
  logic                 done;

  modport master (
    output request,
    output wrenable,
    output addr,
    output wdata,
    input  reqack,
    input  rdata,
    input  done
  );

  modport slave (
    input  request,
    input  wrenable,
    input  addr,
    input  wdata,
    output reqack,
    output rdata,
    output done
  );

endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose: shares the single cache-line memory port between the instruction
// cache (read-only) and the data cache (read/write). Transactions are
// serialised with one outstanding at a time; read data and the done pulse go
// back to whichever cache owns the current transaction. Simultaneous requests
// are resolved round-robin, and the data cache wins the first tie after reset.
// A watchdog flags a transaction that has been outstanding too long.
//
// Ports:
//   clk         : clock
//   reset       : synchronous active-high reset
//   i_bus       : instruction-cache port (slave). wrenable/wdata are ignored,
//                 the I side only ever reads.
//   d_bus       : data-cache port (slave)
//   m_bus       : downstream memory port (master). addr bits [5:0] are
//                 always 0.
//   timeout_err : sticky watchdog error, cleared only by reset
//
// Parameters:
//   AddrWidth     : byte address width
//   LineWidth     : cache line width in bits
//   TimeoutCycles : cycles in ISSUE/WAIT before timeout_err is raised
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AddrWidth     = 64,
  parameter int LineWidth     = 512,
  parameter int TimeoutCycles = 4096
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  i_bus,
  mem_arbiter_if.slave  d_bus,
  mem_arbiter_if.master m_bus,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  // 64-byte lines: the low six address bits select a byte inside the line.
  localparam int          LineOffsetBits = 6;
  localparam logic [31:0] WdLimit        = 32'(TimeoutCycles);

  state_t               state_q, state_d;
  owner_t               owner_q, owner_d;
  logic                 lastGrantD_q, lastGrantD_d;

  logic                 mRequest_q, mRequest_d;
  logic                 mWrenable_q, mWrenable_d;
  logic [AddrWidth-1:0] mAddr_q, mAddr_d;
  logic [LineWidth-1:0] mWdata_q, mWdata_d;

  logic                 iReqack_q, iReqack_d;
  logic                 dReqack_q, dReqack_d;
  logic                 iDone_q, iDone_d;
  logic                 dDone_q, dDone_d;
  logic [LineWidth-1:0] iRdata_q, iRdata_d;
  logic [LineWidth-1:0] dRdata_q, dRdata_d;

  logic [31:0]          wdCount_q, wdCount_d;
  logic                 timeoutErr_q, timeoutErr_d;

  logic                 grantI;
  logic                 grantD;
  logic                 finish;
  logic [AddrWidth-1:0] srcAddr;

  // State and output registers. Reset puts everything back to an idle port
  // with all outputs low and the round-robin pointer set so D wins the first
  // tie; any transaction that was in flight is simply forgotten, so a late
  // m_done afterwards lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      lastGrantD_q <= 1'b0;
      mRequest_q   <= 1'b0;
      mWrenable_q  <= 1'b0;
      mAddr_q      <= '0;
      mWdata_q     <= '0;
      iReqack_q    <= 1'b0;
      dReqack_q    <= 1'b0;
      iDone_q      <= 1'b0;
      dDone_q      <= 1'b0;
      iRdata_q     <= '0;
      dRdata_q     <= '0;
      wdCount_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lastGrantD_q <= lastGrantD_d;
      mRequest_q   <= mRequest_d;
      mWrenable_q  <= mWrenable_d;
      mAddr_q      <= mAddr_d;
      mWdata_q     <= mWdata_d;
      iReqack_q    <= iReqack_d;
      dReqack_q    <= dReqack_d;
      iDone_q      <= iDone_d;
      dDone_q      <= dDone_d;
      iRdata_q     <= iRdata_d;
      dRdata_q     <= dRdata_d;
      wdCount_q    <= wdCount_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // Next-state and next-output logic. Everything holds by default except the
  // reqack and done strobes, which default low so they are single-cycle
  // pulses. Requests are only looked at in IDLE; once a grant is made the
  // address and data are captured and the requester's inputs no longer matter.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lastGrantD_d = lastGrantD_q;
    mRequest_d   = mRequest_q;
    mWrenable_d  = mWrenable_q;
    mAddr_d      = mAddr_q;
    mWdata_d     = mWdata_q;
    iReqack_d    = 1'b0;
    dReqack_d    = 1'b0;
    iDone_d      = 1'b0;
    dDone_d      = 1'b0;
    iRdata_d     = iRdata_q;
    dRdata_d     = dRdata_q;
    wdCount_d    = wdCount_q;
    timeoutErr_d = timeoutErr_q;
    grantI       = 1'b0;
    grantD       = 1'b0;
    finish       = 1'b0;
    srcAddr      = '0;

    case (state_q)
      IDLE: begin
        // D wins when it is alone, or on a tie when I was granted last.
        if (d_bus.request && (!i_bus.request || !lastGrantD_q)) begin
          grantD = 1'b1;
        end else if (i_bus.request) begin
          grantI = 1'b1;
        end

        if (grantD || grantI) begin
          srcAddr      = grantD ? d_bus.addr : i_bus.addr;
          state_d      = ISSUE;
          owner_d      = grantD ? OWN_D : OWN_I;
          lastGrantD_d = grantD;
          mRequest_d   = 1'b1;
          mAddr_d      = {srcAddr[AddrWidth-1:LineOffsetBits], {LineOffsetBits{1'b0}}};
          mWrenable_d  = grantD ? d_bus.wrenable : 1'b0;
          mWdata_d     = grantD ? d_bus.wdata : '0;
          iReqack_d    = grantI;
          dReqack_d    = grantD;
          wdCount_d    = '0;
        end
      end

      ISSUE: begin
        // A done that shows up with or ahead of the accept completes the
        // transaction directly instead of waiting in WAIT for a second one.
        if (m_bus.done) begin
          finish = 1'b1;
        end else if (m_bus.reqack) begin
          mRequest_d  = 1'b0;
          mWrenable_d = 1'b0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (m_bus.done) begin
          finish = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion: hand the line and the done pulse to the owner only; the
    // other side's rdata and done are left untouched.
    if (finish) begin
      state_d     = IDLE;
      owner_d     = OWN_NONE;
      mRequest_d  = 1'b0;
      mWrenable_d = 1'b0;
      if (owner_q == OWN_I) begin
        iRdata_d = m_bus.rdata;
        iDone_d  = 1'b1;
      end else if (owner_q == OWN_D) begin
        dRdata_d = m_bus.rdata;
        dDone_d  = 1'b1;
      end
    end

    // Watchdog: counts every cycle spent in ISSUE or WAIT, saturating so a
    // hung transaction cannot wrap it back below the limit. The error is
    // sticky and does not disturb the transaction itself.
    if (state_q == ISSUE || state_q == WAIT) begin
      if (wdCount_q != '1) begin
        wdCount_d = wdCount_q + 32'd1;
      end
      if (wdCount_d >= WdLimit) begin
        timeoutErr_d = 1'b1;
      end
    end
  end

  // Drive the interface outputs straight from the registers.
  assign i_bus.reqack   = iReqack_q;
  assign i_bus.rdata    = iRdata_q;
  assign i_bus.done     = iDone_q;
  assign d_bus.reqack   = dReqack_q;
  assign d_bus.rdata    = dRdata_q;
  assign d_bus.done     = dDone_q;
  assign m_bus.request  = mRequest_q;
  assign m_bus.wrenable = mWrenable_q;
  assign m_bus.addr     = mAddr_q;
  assign m_bus.wdata    = mWdata_q;
  assign timeout_err    = timeoutErr_q;

  // A grant can only be issued out of IDLE, and only one side can be
  // finishing a transaction at any time.
  reqackFromIdle: assert property (@(posedge clk) disable iff (reset)
    (iReqack_q || dReqack_q) |-> ($past(state_q) == IDLE));

  doneExclusive: assert property (@(posedge clk) disable iff (reset)
    !(iDone_q && dDone_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose: self-checking bench for mem_arbiter. A table of single
// transactions is replayed through applyStimulus, followed by hand-written
// sequences for ties, round-robin order, reset in the middle of a
// transaction, and the watchdog (built here with TimeoutCycles = 16).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int LW = 512;

  localparam logic [LW-1:0] PatA = {16{32'hA5A5_0001}};
  localparam logic [LW-1:0] PatB = {16{32'h5A5A_1234}};
  localparam logic [LW-1:0] PatC = {8{64'hDEAD_BEEF_CAFE_F00D}};
  localparam logic [LW-1:0] PatD = {16{32'h0F0F_7777}};

  typedef struct {
    logic          isD;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            ackDelay;
    int            doneDelay;
    logic [AW-1:0] expAddr;
    logic          expWr;
    logic [LW-1:0] expWdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic timeout_err;

  int passCount = 0;
  int totalChecks = 0;

  logic [LW-1:0] iModel;
  logic [LW-1:0] dModel;
  logic          dKnown;

  mem_arbiter_if #(.AddrWidth(AW), .LineWidth(LW)) iBus ();
  mem_arbiter_if #(.AddrWidth(AW), .LineWidth(LW)) dBus ();
  mem_arbiter_if #(.AddrWidth(AW), .LineWidth(LW)) mBus ();

  mem_arbiter #(
    .AddrWidth    (AW),
    .LineWidth    (LW),
    .TimeoutCycles(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_bus      (iBus),
    .d_bus      (dBus),
    .m_bus      (mBus),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: got still running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    totalChecks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passCount++;
    end
  endtask

  function automatic logic ackOf(input logic d);
    return d ? dBus.reqack : iBus.reqack;
  endfunction

  function automatic logic doneOf(input logic d);
    return d ? dBus.done : iBus.done;
  endfunction

  function automatic logic [LW-1:0] rdataOf(input logic d);
    return d ? dBus.rdata : iBus.rdata;
  endfunction

  task automatic doReset();
    reset         = 1'b1;
    iBus.request  = 1'b0;
    iBus.addr     = '0;
    dBus.request  = 1'b0;
    dBus.wrenable = 1'b0;
    dBus.addr     = '0;
    dBus.wdata    = '0;
    mBus.reqack   = 1'b0;
    mBus.done     = 1'b0;
    mBus.rdata    = '0;
    step();
    step();
    reset  = 1'b0;
    iModel = '0;
    dModel = '0;
    dKnown = 1'b1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " m_request"}, mBus.request, 0);
    checkOutput({tag, " m_wrenable"}, mBus.wrenable, 0);
    checkOutput({tag, " m_addr"}, mBus.addr, 0);
    checkOutput({tag, " m_wdata"}, mBus.wdata, 0);
    checkOutput({tag, " i_reqack"}, iBus.reqack, 0);
    checkOutput({tag, " d_reqack"}, dBus.reqack, 0);
    checkOutput({tag, " i_done"}, iBus.done, 0);
    checkOutput({tag, " d_done"}, dBus.done, 0);
    checkOutput({tag, " i_rdata"}, iBus.rdata, 0);
    checkOutput({tag, " d_rdata"}, dBus.rdata, 0);
    checkOutput({tag, " timeout_err"}, timeout_err, 0);
  endtask

  // One complete transaction: request, grant, downstream accept after
  // ackDelay cycles, done doneDelay cycles after the accept (0 = same cycle).
  task automatic applyStimulus(input vec_t v, input int id);
    if (v.isD) begin
      dBus.request  = 1'b1;
      dBus.wrenable = v.wr;
      dBus.addr     = v.addr;
      dBus.wdata    = v.wdata;
    end else begin
      iBus.request = 1'b1;
      iBus.addr    = v.addr;
    end
    step();
    checkOutput($sformatf("v%0d own_reqack", id), ackOf(v.isD), 1);
    checkOutput($sformatf("v%0d other_reqack", id), ackOf(!v.isD), 0);
    checkOutput($sformatf("v%0d m_request", id), mBus.request, 1);
    checkOutput($sformatf("v%0d m_addr", id), mBus.addr, v.expAddr);
    checkOutput($sformatf("v%0d m_wrenable", id), mBus.wrenable, v.expWr);
    checkOutput($sformatf("v%0d m_wdata", id), mBus.wdata, v.expWdata);

    // Requester lets go and scribbles on its inputs; the latched copy must hold.
    iBus.request  = 1'b0;
    dBus.request  = 1'b0;
    iBus.addr     = '1;
    dBus.addr     = '1;
    dBus.wdata    = ~v.wdata;
    dBus.wrenable = ~v.wr;
    for (int k = 1; k < v.ackDelay; k++) begin
      step();
      checkOutput($sformatf("v%0d hold_m_request", id), mBus.request, 1);
      checkOutput($sformatf("v%0d hold_m_addr", id), mBus.addr, v.expAddr);
      checkOutput($sformatf("v%0d hold_m_wdata", id), mBus.wdata, v.expWdata);
      checkOutput($sformatf("v%0d reqack_single", id), ackOf(v.isD), 0);
    end

    mBus.reqack = 1'b1;
    if (v.doneDelay == 0) begin
      mBus.done  = 1'b1;
      mBus.rdata = v.rdata;
    end
    step();
    mBus.reqack = 1'b0;
    if (v.doneDelay != 0) begin
      checkOutput($sformatf("v%0d m_request_cleared", id), mBus.request, 0);
      checkOutput($sformatf("v%0d m_wrenable_cleared", id), mBus.wrenable, 0);
      checkOutput($sformatf("v%0d early_done", id), doneOf(v.isD), 0);
      for (int k = 1; k < v.doneDelay; k++) begin
        step();
        checkOutput($sformatf("v%0d wait_done", id), doneOf(v.isD), 0);
      end
      mBus.done  = 1'b1;
      mBus.rdata = v.rdata;
      step();
    end
    mBus.done = 1'b0;

    checkOutput($sformatf("v%0d own_done", id), doneOf(v.isD), 1);
    checkOutput($sformatf("v%0d other_done", id), doneOf(!v.isD), 0);
    checkOutput($sformatf("v%0d m_request_idle", id), mBus.request, 0);
    if (!v.wr) begin
      checkOutput($sformatf("v%0d own_rdata", id), rdataOf(v.isD), v.rdata);
    end
    if (v.isD) begin
      checkOutput($sformatf("v%0d i_rdata_kept", id), iBus.rdata, iModel);
      if (v.wr) begin
        dKnown = 1'b0;
      end else begin
        dModel = v.rdata;
        dKnown = 1'b1;
      end
    end else begin
      if (dKnown) begin
        checkOutput($sformatf("v%0d d_rdata_kept", id), dBus.rdata, dModel);
      end
      iModel = v.rdata;
    end

    step();
    checkOutput($sformatf("v%0d done_pulse_end", id), doneOf(v.isD), 0);
  endtask

  task automatic waitGrant(output logic gotD, output logic ok);
    ok   = 1'b0;
    gotD = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      if (iBus.reqack || dBus.reqack) begin
        ok   = 1'b1;
        gotD = dBus.reqack;
      end
    end
  endtask

  initial begin
    vec_t vecs[5];
    logic gotD;
    logic ok;
    logic sawIAck;
    int   iLeft;
    int   dLeft;

    // I read, downstream accept after 2 cycles and done 5 cycles later.
    vecs[0] = '{isD: 1'b0, wr: 1'b0, addr: 64'h1000, wdata: '0, rdata: PatA,
                ackDelay: 2, doneDelay: 5, expAddr: 64'h1000, expWr: 1'b0, expWdata: '0};
    // D write to an unaligned address: line offset bits are dropped.
    vecs[1] = '{isD: 1'b1, wr: 1'b1, addr: 64'h2047, wdata: PatA, rdata: PatD,
                ackDelay: 3, doneDelay: 2, expAddr: 64'h2040, expWr: 1'b1, expWdata: PatA};
    // D read at the top of the address space; d_wdata passes through.
    vecs[2] = '{isD: 1'b1, wr: 1'b0, addr: 64'hFFFF_FFFF_FFFF_FFFF, wdata: PatC, rdata: PatB,
                ackDelay: 1, doneDelay: 1, expAddr: 64'hFFFF_FFFF_FFFF_FFC0, expWr: 1'b0, expWdata: PatC};
    // I read with accept and done in the same cycle.
    vecs[3] = '{isD: 1'b0, wr: 1'b0, addr: 64'h123F, wdata: '0, rdata: PatC,
                ackDelay: 1, doneDelay: 0, expAddr: 64'h1200, expWr: 1'b0, expWdata: '0};
    // D write with accept and done in the same cycle.
    vecs[4] = '{isD: 1'b1, wr: 1'b1, addr: 64'h0040, wdata: PatB, rdata: PatA,
                ackDelay: 1, doneDelay: 0, expAddr: 64'h0040, expWr: 1'b1, expWdata: PatB};

    // The I side never writes; drive junk on its write fields to show they are ignored.
    iBus.wrenable = 1'b1;
    iBus.wdata    = '1;

    $display("[TB] reset state");
    doReset();
    checkQuiet("reset");

    $display("[TB] table-driven transactions");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v], v);
    end

    $display("[TB] tie that is dropped is not remembered");
    doReset();
    iBus.request = 1'b1;
    iBus.addr    = 64'h8000;
    dBus.request = 1'b1;
    dBus.addr    = 64'h9000;
    step();
    checkOutput("tie d_reqack", dBus.reqack, 1);
    checkOutput("tie i_reqack", iBus.reqack, 0);
    iBus.request = 1'b0;
    dBus.request = 1'b0;
    mBus.reqack  = 1'b1;
    mBus.done    = 1'b1;
    mBus.rdata   = PatD;
    step();
    mBus.reqack = 1'b0;
    mBus.done   = 1'b0;
    checkOutput("tie d_done", dBus.done, 1);
    sawIAck = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      sawIAck = sawIAck | iBus.reqack | mBus.request;
    end
    checkOutput("tie i_forgotten", sawIAck, 0);

    $display("[TB] round-robin from reset");
    doReset();
    iBus.addr     = 64'h3000;
    dBus.addr     = 64'h4000;
    dBus.wrenable = 1'b0;
    iBus.request  = 1'b1;
    dBus.request  = 1'b1;
    iLeft = 3;
    dLeft = 3;
    for (int g = 0; g < 6; g++) begin
      waitGrant(gotD, ok);
      checkOutput($sformatf("rr%0d grant_seen", g), ok, 1);
      checkOutput($sformatf("rr%0d grant_is_d", g), gotD, (g % 2 == 0));
      checkOutput($sformatf("rr%0d both_acks", g), iBus.reqack && dBus.reqack, 0);
      checkOutput($sformatf("rr%0d m_addr", g), mBus.addr, gotD ? 64'h4000 : 64'h3000);
      if (gotD) begin
        dBus.request = 1'b0;
        dLeft--;
      end else begin
        iBus.request = 1'b0;
        iLeft--;
      end
      mBus.reqack = 1'b1;
      step();
      mBus.reqack = 1'b0;
      if (dLeft > 0) dBus.request = 1'b1;
      if (iLeft > 0) iBus.request = 1'b1;
      mBus.done  = 1'b1;
      mBus.rdata = gotD ? PatB : PatC;
      step();
      mBus.done = 1'b0;
      checkOutput($sformatf("rr%0d owner_done", g), doneOf(gotD), 1);
      checkOutput($sformatf("rr%0d other_done", g), doneOf(!gotD), 0);
      checkOutput($sformatf("rr%0d no_overlap", g), mBus.request, 0);
    end
    iBus.request = 1'b0;
    dBus.request = 1'b0;
    step();

    $display("[TB] reset in the middle of WAIT");
    iBus.request = 1'b1;
    iBus.addr    = 64'h5000;
    step();
    checkOutput("rstwait i_reqack", iBus.reqack, 1);
    iBus.request = 1'b0;
    mBus.reqack  = 1'b1;
    step();
    mBus.reqack = 1'b0;
    step();
    reset = 1'b1;
    step();
    checkQuiet("rstwait");
    reset      = 1'b0;
    mBus.done  = 1'b1;
    mBus.rdata = PatD;
    step();
    mBus.done = 1'b0;
    checkOutput("rstwait late i_done", iBus.done, 0);
    checkOutput("rstwait late d_done", dBus.done, 0);
    checkOutput("rstwait late i_rdata", iBus.rdata, 0);
    step();
    checkOutput("rstwait late i_done2", iBus.done, 0);
    iModel = '0;
    dModel = '0;
    dKnown = 1'b1;
    applyStimulus('{isD: 1'b0, wr: 1'b0, addr: 64'h6010, wdata: '0, rdata: PatB,
                    ackDelay: 2, doneDelay: 1, expAddr: 64'h6000, expWr: 1'b0, expWdata: '0}, 9);

    $display("[TB] watchdog with done withheld");
    doReset();
    iBus.request = 1'b1;
    iBus.addr    = 64'h7000;
    step();
    checkOutput("wd i_reqack", iBus.reqack, 1);
    iBus.request = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      mBus.reqack = (k == 2);
      step();
    end
    mBus.reqack = 1'b0;
    checkOutput("wd before_limit", timeout_err, 0);
    step();
    checkOutput("wd at_limit", timeout_err, 1);
    for (int k = 0; k < 4; k++) begin
      step();
    end
    mBus.done  = 1'b1;
    mBus.rdata = PatA;
    step();
    mBus.done = 1'b0;
    checkOutput("wd late i_done", iBus.done, 1);
    checkOutput("wd late i_rdata", iBus.rdata, PatA);
    checkOutput("wd sticky", timeout_err, 1);
    step();
    checkOutput("wd sticky2", timeout_err, 1);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
